// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: oversampled SCK/SSEL/MOSI, any CPOL/CPHA, MSB/LSB first.
// Receive words come out as a one-clk strobe; transmit words come in through a one-word holding buffer.
module spi_slave_param #(
  parameter int                WORD_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_FILL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic {StIdle, StActive} state_e;

  logic [2:0]        sckSync_q, sselSync_q;
  logic [1:0]        mosiSync_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [WORD_W-1:0] rxShift_q, rxShift_d;
  logic [WORD_W-1:0] rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic [WORD_W-1:0] txShift_q, txShift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              holdFull_q, holdFull_d;
  logic              underrun_q, underrun_d;

  logic sckRise, sckFall, leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic sselHigh, sselFall, inMsg, doSample, doShift, startMsg, wordLoad, txAccept;

  // Synchronisers reset to the idle pin levels so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sckSync_q  <= {3{CPOL}};
      sselSync_q <= 3'b111;
      mosiSync_q <= 2'b00;
    end else begin
      sckSync_q  <= {sckSync_q[1:0], SCK};
      sselSync_q <= {sselSync_q[1:0], SSEL};
      mosiSync_q <= {mosiSync_q[0], MOSI};
    end
  end

  assign sckRise    = sckSync_q[1] & ~sckSync_q[2];
  assign sckFall    = ~sckSync_q[1] & sckSync_q[2];
  assign leadEdge   = CPOL ? sckFall : sckRise;
  assign trailEdge  = CPOL ? sckRise : sckFall;
  assign sampleEdge = CPHA ? trailEdge : leadEdge;
  assign shiftEdge  = CPHA ? leadEdge : trailEdge;

  // A deasserted select outranks any SCK edge seen on the same clk.
  assign sselHigh = sselSync_q[1];
  assign sselFall = ~sselSync_q[1] & sselSync_q[2];
  assign inMsg    = (state_q == StActive) && !sselHigh;
  assign doSample = inMsg && sampleEdge;
  assign doShift  = inMsg && shiftEdge;
  assign startMsg = (state_q == StIdle) && sselFall;
  assign wordLoad = (doShift && (bitCnt_q == '0)) || (!CPHA && startMsg);
  assign txAccept = tx_valid && !holdFull_q;

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    txShift_d  = txShift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    underrun_d = 1'b0;

    case (state_q)
      StIdle:   if (sselFall) state_d = StActive;
      StActive: if (sselHigh) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (!inMsg) begin
      bitCnt_d = '0;
    end else if (doSample) begin
      bitCnt_d = (bitCnt_q == LAST_BIT) ? '0 : bitCnt_q + CNT_W'(1);
    end

    if (doSample) begin
      rxShift_d = MSB_FIRST ? {rxShift_q[WORD_W-2:0], mosiSync_q[1]}
                            : {mosiSync_q[1], rxShift_q[WORD_W-1:1]};
      if (bitCnt_q == LAST_BIT) begin
        rxData_d  = rxShift_d;
        rxValid_d = 1'b1;
      end
    end

    // A load always drains the buffer; a same-clk write refills it for the next word.
    if (wordLoad) begin
      txShift_d  = holdFull_q ? hold_q : IDLE_FILL;
      underrun_d = !holdFull_q;
      holdFull_d = 1'b0;
    end else if (doShift) begin
      txShift_d = MSB_FIRST ? {txShift_q[WORD_W-2:0], 1'b0}
                            : {1'b0, txShift_q[WORD_W-1:1]};
    end

    if (txAccept) begin
      hold_d     = tx_data;
      holdFull_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      txShift_q  <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      txShift_q  <= txShift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      underrun_q <= underrun_d;
    end
  end

  assign MISO        = MSB_FIRST ? txShift_q[WORD_W-1] : txShift_q[0];
  assign MISO_oe     = (state_q == StActive);
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign tx_ready    = !holdFull_q;
  assign tx_underrun = underrun_q;

endmodule
